mmio_input_reader: RTL and testbench
====================================

Name: mmio_input_reader

Overview:
- Memory-mapped input peripheral on the read side of the data-memory I/O window. The store path drives LEDs and HEX at 0x3FC–0x3FE; this block serves loads from 0x3F8–0x3FB.
- Synchronizes and debounces board switches and push-buttons, latches sticky key-press events, and maintains a free-running cycle counter.
- Presents read data to the memory stage's load mux. When O_RdHit=1, the memory stage selects O_RdData instead of DataMem.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles a key must hold before its debounced state changes (1 ms at 50 MHz); minimum 2.
- DB_CNT_WIDTH, 16, width of each per-key debounce counter; must hold DEBOUNCE_CYCLES.
- ADDR_SW, 10'h3F8, switch read address.
- ADDR_KEY, 10'h3F9, debounced key-level read address.
- ADDR_KEYEVT, 10'h3FA, sticky key-event read address; read-to-clear.
- ADDR_TIMER, 10'h3FB, cycle-counter read address.

Ports:
- I_CLOCK  in  1  pipeline clock; all state updates on negedge, same edge as the memory stage.
- I_LOCK  in  1  asynchronous active-low reset (0 = reset).
- I_SW  in  10  raw slide switches, asynchronous.
- I_KEY  in  4  raw push-buttons, asynchronous, active-low (0 = pressed).
- I_RdValid  in  1  a load instruction is valid in the memory stage (EX valid and opcode LDW).
- I_RdAddr  in  10  low 10 bits of MAR.
- O_RdHit  out  1  combinational; 1 when I_RdValid=1 and I_RdAddr matches one of the four addresses.
- O_RdData  out  16  combinational read data; 16'h0000 when O_RdHit=0.
- O_KeyEvtAny  out  1  registered; OR of the sticky event bits.

Behaviour:
- Reset (I_LOCK=0, async):
  - SW and KEY sync flops cleared to 10'h000 and 4'hF respectively.
  - Debounced keys = 4'hF (released); debounce counters = 0.
  - Event bits = 4'h0; timer = 16'h0000; O_KeyEvtAny = 0.
  - O_RdHit and O_RdData follow the combinational rules from the reset state.
- Synchronizers: two-flop chain per bit for SW and KEY. A raw change is visible in sync stage 2 after two negedges.
- Switch read path: no debounce. Read of ADDR_SW returns {6'b0, sw_sync2}.
- Per-key debounce, each negedge:
  - If key_sync2 == key_db: counter is set to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, key_db takes key_sync2 and the counter is set to 0.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Press event: a key_db transition 1→0 sets evt[i] on the same edge as the key_db update. Release sets nothing.
- Read-to-clear: on a negedge with I_RdValid=1 and I_RdAddr=ADDR_KEYEVT, evt is cleared.
  - O_RdData during that cycle shows the pre-clear value.
  - If a press sets the same bit on that edge, set wins: the bit is 1 afterwards.
- Other read data:
  - ADDR_KEY returns {12'b0, ~key_db}, i.e. 1 = pressed.
  - ADDR_KEYEVT returns {12'b0, evt}.
  - ADDR_TIMER returns the timer.
- Timer: increments every negedge while I_LOCK=1; wraps 16'hFFFF→16'h0000 with no flag.
- Reads of ADDR_SW, ADDR_KEY and ADDR_TIMER have no side effects.
- Unmatched address or I_RdValid=0: O_RdHit=0, O_RdData=0, no side effect.
- O_KeyEvtAny = |evt, registered; it lags the evt update by 0 edges, being computed from evt's next value.
- Reset mid-debounce or with pending events discards all state; no event is generated on release of reset even if a key is held.

Test Plan:
- Hold I_LOCK=0 with I_KEY=4'h0, then release. Required: evt=0 and ADDR_KEYEVT read = 16'h0000. After DEBOUNCE_CYCLES+2 edges, ADDR_KEY read = 16'h000F and evt=4'hF.
- I_SW=10'h2A5 applied. Required: ADDR_SW read = 16'h0000 after 1 edge and 16'h02A5 after 2 edges; O_RdHit=1. With I_RdValid=0: O_RdHit=0 and O_RdData=0.
- DEBOUNCE_CYCLES=4; pulse KEY[1] low for 3 cycles. Required: no event. Hold it low for 6 cycles. Required: evt=4'h2 exactly 2+4 edges after the fall; O_KeyEvtAny=1.
- Read ADDR_KEYEVT with evt=4'h2. Required: returns 16'h0002. Next-cycle read returns 16'h0000 and O_KeyEvtAny=0.
- KEY[0] debounce completes on the same edge as an ADDR_KEYEVT read. Required: the read returns the old value and evt[0]=1 afterwards.
- Timer preloaded via reset and run to 16'hFFFE; read on consecutive cycles. Required: returns 16'hFFFE, 16'hFFFF, 16'h0000. Assert I_LOCK=0 mid-count: the timer reads 16'h0000 immediately (async).

Source files
------------

// File: rtl/mmio_input_reader.sv
// mmio_input_reader: load-side MMIO port serving synchronized switches, debounced keys,
// sticky key-press events (read-to-clear) and a free-running cycle timer.
module mmio_input_reader #(
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         DB_CNT_WIDTH    = 16,
    parameter logic [9:0] ADDR_SW         = 10'h3F8,
    parameter logic [9:0] ADDR_KEY        = 10'h3F9,
    parameter logic [9:0] ADDR_KEYEVT     = 10'h3FA,
    parameter logic [9:0] ADDR_TIMER      = 10'h3FB
) (
    input  logic        I_CLOCK,
    input  logic        I_LOCK,
    input  logic [9:0]  I_SW,
    input  logic [3:0]  I_KEY,
    input  logic        I_RdValid,
    input  logic [9:0]  I_RdAddr,
    output logic        O_RdHit,
    output logic [15:0] O_RdData,
    output logic        O_KeyEvtAny
);
    logic [9:0] sw_s1, sw_s2;
    logic [3:0] key_s1, key_s2, key_db, db_next, evt, evt_next;
    logic [3:0][DB_CNT_WIDTH-1:0] cnt, cnt_next;
    logic [15:0] timer;
    logic sel_sw, sel_key, sel_evt, sel_tmr;

    assign sel_sw  = I_RdValid && I_RdAddr == ADDR_SW;
    assign sel_key = I_RdValid && I_RdAddr == ADDR_KEY;
    assign sel_evt = I_RdValid && I_RdAddr == ADDR_KEYEVT;
    assign sel_tmr = I_RdValid && I_RdAddr == ADDR_TIMER;
    assign O_RdHit = sel_sw | sel_key | sel_evt | sel_tmr;
    assign O_RdData = sel_sw  ? {6'b0, sw_s2} :
                      sel_key ? {12'b0, ~key_db} :
                      sel_evt ? {12'b0, evt} :
                      sel_tmr ? timer : 16'h0000;

    // a press landing on the clearing edge survives because the set term is ORed in last
    always_comb begin
        db_next  = key_db;
        cnt_next = '0;
        for (int i = 0; i < 4; i++)
            if (key_s2[i] != key_db[i]) begin
                if (cnt[i] == DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) db_next[i] = key_s2[i];
                else cnt_next[i] = cnt[i] + DB_CNT_WIDTH'(1);
            end
        evt_next = (sel_evt ? 4'h0 : evt) | (key_db & ~db_next);
    end

    always_ff @(negedge I_CLOCK or negedge I_LOCK)
        if (!I_LOCK) begin
            sw_s1       <= '0;
            sw_s2       <= '0;
            key_s1      <= 4'hF;
            key_s2      <= 4'hF;
            key_db      <= 4'hF;
            cnt         <= '0;
            evt         <= '0;
            O_KeyEvtAny <= 1'b0;
            timer       <= '0;
        end else begin
            sw_s1       <= I_SW;
            sw_s2       <= sw_s1;
            key_s1      <= I_KEY;
            key_s2      <= key_s1;
            key_db      <= db_next;
            cnt         <= cnt_next;
            evt         <= evt_next;
            O_KeyEvtAny <= |evt_next;
            timer       <= timer + 16'd1;
        end
endmodule

// File: tb/tb_mmio_input_reader.sv
// tb_mmio_input_reader: directed stimulus with a sample-history reference model compared
// every cycle, plus literal checks of the key scenarios.
module tb_mmio_input_reader;
    localparam int DC = 4;
    localparam logic [9:0] A_SW = 10'h3F8, A_KEY = 10'h3F9, A_EVT = 10'h3FA, A_TMR = 10'h3FB;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [9:0] sw = '0;
    logic [3:0] key = '0;
    logic rd_valid = 1'b0;
    logic [9:0] rd_addr = '0;
    logic hit, evt_any;
    logic [15:0] rd_data;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mmio_input_reader #(.DEBOUNCE_CYCLES(DC), .DB_CNT_WIDTH(16)) dut (
        .I_CLOCK(clk), .I_LOCK(rst_n), .I_SW(sw), .I_KEY(key),
        .I_RdValid(rd_valid), .I_RdAddr(rd_addr),
        .O_RdHit(hit), .O_RdData(rd_data), .O_KeyEvtAny(evt_any)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // model: raw samples seen two edges ago are the synchronized view; a key flips once
    // its last DC synchronized samples all disagree with the debounced level
    logic [13:0] raw_q[$];
    logic [3:0] win[$];
    logic [3:0] m_db = 4'hF, m_evt = 4'h0;
    logic [15:0] m_timer = 16'h0;

    always @(negedge clk or negedge rst_n) begin : mdl
        logic [3:0] ks, old_db;
        bit all;
        if (!rst_n) begin
            raw_q = '{14'h00F, 14'h00F};
            win = {};
            m_db = 4'hF;
            m_evt = 4'h0;
            m_timer = 16'h0;
        end else begin
            ks = raw_q[0][3:0];
            win.push_back(ks);
            if (win.size() > DC) void'(win.pop_front());
            old_db = m_db;
            if (win.size() == DC)
                for (int i = 0; i < 4; i++) begin
                    all = 1;
                    for (int j = 0; j < DC; j++) if (win[j][i] == old_db[i]) all = 0;
                    if (all) m_db[i] = ~old_db[i];
                end
            if (rd_valid && rd_addr == A_EVT) m_evt = 4'h0;
            m_evt = m_evt | (old_db & ~m_db);
            m_timer = m_timer + 16'd1;
            raw_q.push_back({sw, key});
            void'(raw_q.pop_front());
        end
    end

    always @(posedge clk) begin : cmp
        logic e_hit;
        logic [15:0] e_data;
        logic [13:0] r;
        r = raw_q[0];
        e_hit = rd_valid && (rd_addr == A_SW || rd_addr == A_KEY || rd_addr == A_EVT || rd_addr == A_TMR);
        e_data = !e_hit ? 16'h0 :
                 rd_addr == A_SW ? {6'b0, r[13:4]} :
                 rd_addr == A_KEY ? {12'b0, ~m_db} :
                 rd_addr == A_EVT ? {12'b0, m_evt} : m_timer;
        chk("cmp_hit", {15'b0, hit}, {15'b0, e_hit});
        chk("cmp_data", rd_data, e_data);
        chk("cmp_evt_any", {15'b0, evt_any}, {15'b0, |m_evt});
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [9:0] a);
        rd_valid = 1'b1;
        rd_addr = a;
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        key = 4'h0;
        step(3);
        rd(A_EVT);
        chk("rst_evt_rd", rd_data, 16'h0000);
        chk("rst_hit", {15'b0, hit}, 16'h0001);
        chk("rst_evt_any", {15'b0, evt_any}, 16'h0000);
        rd(A_TMR);
        chk("rst_timer", rd_data, 16'h0000);
        rd_valid = 1'b0;
        rst_n = 1'b1;
        step(DC + 1);
        chk("held_before", {15'b0, evt_any}, 16'h0000);
        step(1);
        chk("held_evt_any", {15'b0, evt_any}, 16'h0001);
        rd(A_KEY);
        chk("held_key", rd_data, 16'h000F);
        rd(A_EVT);
        chk("held_evt", rd_data, 16'h000F);
        rd_valid = 1'b0;
        key = 4'hF;
        step(10);
        rd(A_EVT);
        step(1);
        rd_valid = 1'b0;
        #1 chk("cleared_any", {15'b0, evt_any}, 16'h0000);

        sw = 10'h2A5;
        rd(A_SW);
        step(1);
        chk("sw_1edge", rd_data, 16'h0000);
        step(1);
        chk("sw_2edge", rd_data, 16'h02A5);
        chk("sw_hit", {15'b0, hit}, 16'h0001);
        rd_valid = 1'b0;
        #1;
        chk("idle_hit", {15'b0, hit}, 16'h0000);
        chk("idle_data", rd_data, 16'h0000);

        key = 4'hD;
        step(3);
        key = 4'hF;
        step(10);
        chk("glitch_any", {15'b0, evt_any}, 16'h0000);
        rd(A_EVT);
        chk("glitch_evt", rd_data, 16'h0000);
        rd_valid = 1'b0;

        key = 4'hD;
        step(5);
        chk("k1_early", {15'b0, evt_any}, 16'h0000);
        step(1);
        chk("k1_any", {15'b0, evt_any}, 16'h0001);
        rd(A_EVT);
        chk("k1_evt", rd_data, 16'h0002);
        step(1);
        chk("k1_clr", rd_data, 16'h0000);
        chk("k1_clr_any", {15'b0, evt_any}, 16'h0000);
        rd_valid = 1'b0;
        key = 4'hF;
        step(10);
        chk("release_none", {15'b0, evt_any}, 16'h0000);

        key = 4'hE;
        step(5);
        rd(A_EVT);
        chk("same_old", rd_data, 16'h0000);
        step(1);
        chk("same_new", rd_data, 16'h0001);
        chk("same_any", {15'b0, evt_any}, 16'h0001);
        rd_valid = 1'b0;
        key = 4'hF;
        step(10);

        rst_n = 1'b0;
        #1;
        rd(A_TMR);
        chk("tmr_rst", rd_data, 16'h0000);
        rst_n = 1'b1;
        step(65534);
        chk("tmr_fffe", rd_data, 16'hFFFE);
        step(1);
        chk("tmr_ffff", rd_data, 16'hFFFF);
        step(1);
        chk("tmr_wrap", rd_data, 16'h0000);
        step(5);
        chk("tmr_5", rd_data, 16'h0005);
        rst_n = 1'b0;
        #1;
        chk("tmr_async", rd_data, 16'h0000);
        rst_n = 1'b1;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
